// File: rtl/gpu_blitter.sv
// CLEAR / XOR-sprite DRAW engine for a byte-packed 1bpp framebuffer in shared memory.
// Optional build macro GPU_BLIT_ROWCOUNT_EN adds the gpu_collision_rows output.
`timescale 1ns/1ps
module gpu_blitter #(
    parameter int FB_WIDTH  = 64,
    parameter int FB_HEIGHT = 32,
    parameter int FB_BASE   = 'h100,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        gpu_cmd,
    input  logic              gpu_cmd_submitted,
    input  logic [ADDR_W-1:0] gpu_draw_offset,
    input  logic [3:0]        gpu_draw_length,
    input  logic [7:0]        gpu_draw_x,
    input  logic [7:0]        gpu_draw_y,
    input  logic              gpu_clip_mode,
    output logic              gpu_ready,
    output logic              gpu_done,
    output logic              gpu_collision,
`ifdef GPU_BLIT_ROWCOUNT_EN
    output logic [4:0]        gpu_collision_rows,
`endif
    output logic              gpu_mem_read,
    output logic [ADDR_W-1:0] gpu_mem_read_addr,
    input  logic [7:0]        gpu_mem_read_data,
    input  logic              gpu_mem_read_ack,
    output logic              gpu_mem_write,
    output logic [ADDR_W-1:0] gpu_mem_write_addr,
    output logic [7:0]        gpu_mem_write_data
);

    localparam logic [3:0] GPU_CMD_CLEAR = 4'h0;
    localparam logic [3:0] GPU_CMD_DRAW  = 4'h1;

    localparam int STRIDE   = FB_WIDTH / 8;
    localparam int FB_BYTES = STRIDE * FB_HEIGHT;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(FB_BASE);
    localparam logic [7:0]        X_MASK   = 8'(FB_WIDTH - 1);
    localparam logic [7:0]        Y_MASK   = 8'(FB_HEIGHT - 1);
    localparam logic [7:0]        LAST_COL = 8'(STRIDE - 1);
    localparam logic [15:0]       CLR_LAST = 16'(FB_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_CLEAR, S_FETCH, S_WAIT_SPR,
        S_RD_L, S_RD_R, S_WR_L, S_WR_R, S_NEXT, S_FINISH
    } state_t;

    state_t            state_reg;
    logic [3:0]        cmd_reg;
    logic [ADDR_W-1:0] offset_reg;
    logic [3:0]        len_reg;
    logic [7:0]        x_reg;
    logic [7:0]        y_reg;
    logic              clip_reg;
    logic [7:0]        x0_reg;
    logic [7:0]        y0_reg;
    logic [2:0]        shift_reg;
    logic [3:0]        row_reg;
    logic [15:0]       line_reg;
    logic [ADDR_W-1:0] left_addr_reg;
    logic [ADDR_W-1:0] right_addr_reg;
    logic              right_used_reg;
    logic              row_hit_reg;
    logic [15:0]       clr_cnt_reg;

    logic [8:0]        y_full;
    logic [8:0]        y_wrap;
    logic              y_clipped;
    logic [7:0]        col_l;
    logic              right_edge;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] left_addr;
    logic [ADDR_W-1:0] right_addr;
    logic              right_needed;
    logic              ack_ok;

    assign gpu_ready = (state_reg == S_IDLE);
    // An ack coinciding with our own request strobe cannot belong to it.
    assign ack_ok = gpu_mem_read_ack && !gpu_mem_read;

    // Row/column addressing for the current sprite row.
    always_comb begin
        y_full       = {1'b0, y0_reg} + {5'b0, row_reg};
        y_wrap       = y_full & {1'b0, Y_MASK};
        y_clipped    = clip_reg && (y_full >= 9'(FB_HEIGHT));
        col_l        = {3'b000, x0_reg[7:3]};
        right_edge   = (col_l == LAST_COL);
        row_base     = BASE + ADDR_W'(32'(y_wrap) * STRIDE);
        left_addr    = row_base + ADDR_W'(col_l);
        right_addr   = right_edge ? row_base : left_addr + ADDR_W'(1);
        right_needed = (shift_reg != 3'd0) && !(right_edge && clip_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            cmd_reg            <= '0;
            offset_reg         <= '0;
            len_reg            <= '0;
            x_reg              <= '0;
            y_reg              <= '0;
            clip_reg           <= 1'b0;
            x0_reg             <= '0;
            y0_reg             <= '0;
            shift_reg          <= '0;
            row_reg            <= '0;
            line_reg           <= '0;
            left_addr_reg      <= '0;
            right_addr_reg     <= '0;
            right_used_reg     <= 1'b0;
            row_hit_reg        <= 1'b0;
            clr_cnt_reg        <= '0;
            gpu_done           <= 1'b0;
            gpu_collision      <= 1'b0;
`ifdef GPU_BLIT_ROWCOUNT_EN
            gpu_collision_rows <= '0;
`endif
            gpu_mem_read       <= 1'b0;
            gpu_mem_read_addr  <= '0;
            gpu_mem_write      <= 1'b0;
            gpu_mem_write_addr <= '0;
            gpu_mem_write_data <= '0;
        end else begin
            gpu_mem_read  <= 1'b0;
            gpu_mem_write <= 1'b0;
            gpu_done      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (gpu_cmd_submitted) begin
                        cmd_reg    <= gpu_cmd;
                        offset_reg <= gpu_draw_offset;
                        len_reg    <= gpu_draw_length;
                        x_reg      <= gpu_draw_x;
                        y_reg      <= gpu_draw_y;
                        clip_reg   <= gpu_clip_mode;
                        state_reg  <= S_DECODE;
`ifdef GPU_BLIT_ROWCOUNT_EN
                        if (gpu_cmd == GPU_CMD_DRAW) gpu_collision_rows <= '0;
`endif
                    end
                end
                S_DECODE: begin
                    if (cmd_reg == GPU_CMD_CLEAR) begin
                        clr_cnt_reg <= '0;
                        state_reg   <= S_CLEAR;
                    end else if (cmd_reg == GPU_CMD_DRAW) begin
                        gpu_collision <= 1'b0;
                        x0_reg        <= x_reg & X_MASK;
                        y0_reg        <= y_reg & Y_MASK;
                        shift_reg     <= x_reg[2:0];
                        row_reg       <= '0;
                        if (len_reg == 4'd0) begin
                            gpu_done  <= 1'b1;
                            state_reg <= S_FINISH;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end else begin
                        gpu_done  <= 1'b1;
                        state_reg <= S_FINISH;
                    end
                end
                S_CLEAR: begin
                    gpu_mem_write      <= 1'b1;
                    gpu_mem_write_addr <= BASE + ADDR_W'(clr_cnt_reg);
                    gpu_mem_write_data <= 8'h00;
                    clr_cnt_reg        <= clr_cnt_reg + 16'd1;
                    if (clr_cnt_reg == CLR_LAST) begin
                        gpu_done  <= 1'b1;
                        state_reg <= S_FINISH;
                    end
                end
                S_FETCH: begin
                    gpu_mem_read      <= 1'b1;
                    gpu_mem_read_addr <= offset_reg + ADDR_W'(row_reg);
                    state_reg         <= S_WAIT_SPR;
                end
                S_WAIT_SPR: begin
                    if (ack_ok) begin
                        line_reg    <= {gpu_mem_read_data, 8'h00} >> shift_reg;
                        row_hit_reg <= 1'b0;
                        if (y_clipped) begin
                            gpu_done  <= 1'b1;
                            state_reg <= S_FINISH;
`ifdef GPU_BLIT_ROWCOUNT_EN
                            // Rows falling off the bottom count as collided rows.
                            gpu_collision_rows <= gpu_collision_rows + {1'b0, len_reg - row_reg};
                            gpu_collision      <= 1'b1;
`endif
                        end else begin
                            gpu_mem_read      <= 1'b1;
                            gpu_mem_read_addr <= left_addr;
                            left_addr_reg     <= left_addr;
                            right_addr_reg    <= right_addr;
                            right_used_reg    <= right_needed;
                            state_reg         <= S_RD_L;
                        end
                    end
                end
                S_RD_L: begin
                    if (ack_ok) begin
                        line_reg[15:8] <= line_reg[15:8] ^ gpu_mem_read_data;
                        if (|(gpu_mem_read_data & line_reg[15:8])) begin
                            gpu_collision <= 1'b1;
                            row_hit_reg   <= 1'b1;
                        end
                        if (right_used_reg) begin
                            gpu_mem_read      <= 1'b1;
                            gpu_mem_read_addr <= right_addr_reg;
                            state_reg         <= S_RD_R;
                        end else begin
                            state_reg <= S_WR_L;
                        end
                    end
                end
                S_RD_R: begin
                    if (ack_ok) begin
                        line_reg[7:0] <= line_reg[7:0] ^ gpu_mem_read_data;
                        if (|(gpu_mem_read_data & line_reg[7:0])) begin
                            gpu_collision <= 1'b1;
                            row_hit_reg   <= 1'b1;
                        end
                        state_reg <= S_WR_L;
                    end
                end
                S_WR_L: begin
                    gpu_mem_write      <= 1'b1;
                    gpu_mem_write_addr <= left_addr_reg;
                    gpu_mem_write_data <= line_reg[15:8];
                    state_reg          <= right_used_reg ? S_WR_R : S_NEXT;
                end
                S_WR_R: begin
                    gpu_mem_write      <= 1'b1;
                    gpu_mem_write_addr <= right_addr_reg;
                    gpu_mem_write_data <= line_reg[7:0];
                    state_reg          <= S_NEXT;
                end
                S_NEXT: begin
                    row_reg <= row_reg + 4'd1;
`ifdef GPU_BLIT_ROWCOUNT_EN
                    if (row_hit_reg) gpu_collision_rows <= gpu_collision_rows + 5'd1;
`endif
                    if (row_reg + 4'd1 == len_reg) begin
                        gpu_done  <= 1'b1;
                        state_reg <= S_FINISH;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_FINISH: state_reg <= S_IDLE;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_blitter.sv
// Directed bench for gpu_blitter: DRAW vector table plus CLEAR and mid-command reset sequences.
`timescale 1ns/1ps
module tb_gpu_blitter;

    localparam logic [3:0] CMD_CLEAR = 4'h0;
    localparam logic [3:0] CMD_DRAW  = 4'h1;
    localparam int         LAT       = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  gpu_cmd;
    logic        gpu_cmd_submitted;
    logic [11:0] gpu_draw_offset;
    logic [3:0]  gpu_draw_length;
    logic [7:0]  gpu_draw_x;
    logic [7:0]  gpu_draw_y;
    logic        gpu_clip_mode;
    logic        gpu_ready;
    logic        gpu_done;
    logic        gpu_collision;
`ifdef GPU_BLIT_ROWCOUNT_EN
    logic [4:0]  gpu_collision_rows;
`endif
    logic        gpu_mem_read;
    logic [11:0] gpu_mem_read_addr;
    logic [7:0]  gpu_mem_read_data;
    logic        gpu_mem_read_ack;
    logic        gpu_mem_write;
    logic [11:0] gpu_mem_write_addr;
    logic [7:0]  gpu_mem_write_data;

    always #5 clk = ~clk;

    gpu_blitter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .gpu_cmd            (gpu_cmd),
        .gpu_cmd_submitted  (gpu_cmd_submitted),
        .gpu_draw_offset    (gpu_draw_offset),
        .gpu_draw_length    (gpu_draw_length),
        .gpu_draw_x         (gpu_draw_x),
        .gpu_draw_y         (gpu_draw_y),
        .gpu_clip_mode      (gpu_clip_mode),
        .gpu_ready          (gpu_ready),
        .gpu_done           (gpu_done),
        .gpu_collision      (gpu_collision),
`ifdef GPU_BLIT_ROWCOUNT_EN
        .gpu_collision_rows (gpu_collision_rows),
`endif
        .gpu_mem_read       (gpu_mem_read),
        .gpu_mem_read_addr  (gpu_mem_read_addr),
        .gpu_mem_read_data  (gpu_mem_read_data),
        .gpu_mem_read_ack   (gpu_mem_read_ack),
        .gpu_mem_write      (gpu_mem_write),
        .gpu_mem_write_addr (gpu_mem_write_addr),
        .gpu_mem_write_data (gpu_mem_write_data)
    );

    // Shared memory model and bus monitor; sole owner of everything it counts.
    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
        logic [31:0] c;
    } wr_t;

    logic [7:0] mem [0:4095];
    wr_t        wlog[$];
    int         cyc, n_dones, n_overlap, n_outerr, n_reads;

    initial begin
        int rd_cnt;
        logic rd_pend;
        logic [11:0] rd_addr;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 'h100; i < 'h200; i++) mem[i] = 8'hAA;
        mem['h000] = 8'hF0;
        mem['h010] = 8'hFF;
        mem['h011] = 8'hFF;
        cyc = 0; n_dones = 0; n_overlap = 0; n_outerr = 0; n_reads = 0;
        rd_pend = 1'b0; rd_cnt = 0; rd_addr = '0;
        gpu_mem_read_ack  = 1'b0;
        gpu_mem_read_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            gpu_mem_read_ack = 1'b0;
            if (!rst_n) begin
                rd_pend = 1'b0;
            end else begin
                if (rd_pend) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        gpu_mem_read_ack  = 1'b1;
                        gpu_mem_read_data = mem[rd_addr];
                        rd_pend = 1'b0;
                    end
                end
                if (gpu_mem_read) begin
                    if (rd_pend) n_outerr++;
                    rd_pend = 1'b1;
                    rd_addr = gpu_mem_read_addr;
                    rd_cnt  = LAT;
                    n_reads++;
                end
                if (gpu_mem_write) begin
                    mem[gpu_mem_write_addr] = gpu_mem_write_data;
                    wlog.push_back('{a: gpu_mem_write_addr, d: gpu_mem_write_data, c: 32'(cyc)});
                end
                if (gpu_mem_read && gpu_mem_write) n_overlap++;
                if (gpu_done) n_dones++;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int base_log, base_dones, base_overlap, base_outerr, base_reads;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_cmd(input logic [3:0] cmd, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] len, input logic clip, input logic [11:0] off);
        @(posedge clk); #1;
        base_log     = wlog.size();
        base_dones   = n_dones;
        base_overlap = n_overlap;
        base_outerr  = n_outerr;
        base_reads   = n_reads;
        gpu_cmd = cmd; gpu_draw_x = x; gpu_draw_y = y; gpu_draw_length = len;
        gpu_clip_mode = clip; gpu_draw_offset = off; gpu_cmd_submitted = 1'b1;
        @(posedge clk); #1;
        gpu_cmd_submitted = 1'b0;
        // The engine must work from its captured copy, not the live inputs.
        gpu_cmd = 4'h7; gpu_draw_x = 8'h55; gpu_draw_y = 8'h55; gpu_draw_length = 4'hF;
        gpu_clip_mode = ~clip; gpu_draw_offset = 12'h555;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (n_dones == base_dones && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_done_seen"}, 32'(n_dones != base_dones), 32'd1);
        chk({tag, "_ready_after"}, 32'(gpu_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(n_dones - base_dones), 32'd1);
        chk({tag, "_rd_wr_overlap"}, 32'(n_overlap - base_overlap), 32'd0);
        chk({tag, "_rd_outstanding"}, 32'(n_outerr - base_outerr), 32'd0);
    endtask

    task automatic do_clear(input string tag, input logic exp_coll, input bit poke);
        int nw, errs;
        start_cmd(CMD_CLEAR, 8'd0, 8'd0, 4'd0, 1'b0, 12'h000);
        if (poke) begin
            repeat (10) @(posedge clk);
            #1;
            gpu_cmd = CMD_DRAW; gpu_draw_length = 4'd1; gpu_cmd_submitted = 1'b1;
            @(posedge clk); #1;
            gpu_cmd_submitted = 1'b0;
        end
        wait_done(tag);
        nw = wlog.size() - base_log;
        chk({tag, "_nwrites"}, 32'(nw), 32'd256);
        errs = 0;
        for (int k = 0; k < nw && k < 256; k++) begin
            if (wlog[base_log + k].a !== 12'('h100 + k)) errs++;
            if (wlog[base_log + k].d !== 8'h00) errs++;
            if (wlog[base_log + k].c !== wlog[base_log].c + 32'(k)) errs++;
        end
        chk({tag, "_seq_errors"}, 32'(errs), 32'd0);
        chk({tag, "_collision"}, 32'(gpu_collision), 32'(exp_coll));
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  len;
        logic        clip;
        logic [11:0] off;
        int          nwr;
        logic [11:0] wa [4];
        logic [7:0]  wd [4];
        logic        coll;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic [3:0] cmd, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] len, input logic clip, input logic [11:0] off,
                           input int nwr, input logic coll,
                           input logic [11:0] a0, input logic [7:0] d0, input logic [11:0] a1, input logic [7:0] d1,
                           input logic [11:0] a2, input logic [7:0] d2, input logic [11:0] a3, input logic [7:0] d3);
        vecs[i].cmd = cmd; vecs[i].x = x; vecs[i].y = y; vecs[i].len = len;
        vecs[i].clip = clip; vecs[i].off = off; vecs[i].nwr = nwr; vecs[i].coll = coll;
        vecs[i].wa[0] = a0; vecs[i].wd[0] = d0; vecs[i].wa[1] = a1; vecs[i].wd[1] = d1;
        vecs[i].wa[2] = a2; vecs[i].wd[2] = d2; vecs[i].wa[3] = a3; vecs[i].wd[3] = d3;
    endtask

    initial begin
        int t, nw;
        rst_n = 1'b0;
        gpu_cmd = '0; gpu_cmd_submitted = 1'b0; gpu_draw_offset = '0; gpu_draw_length = '0;
        gpu_draw_x = '0; gpu_draw_y = '0; gpu_clip_mode = 1'b0;

        // Framebuffer 64x32 at 0x100, stride 8; sprites: 0x000=F0, 0x010/0x011=FF,FF.
        //       i  cmd        x      y      len    clip  off     n  coll  writes
        set_vec(0, CMD_DRAW,  8'd0,  8'd0,  4'd1,  1'b0, 12'h000, 1, 1'b0, 12'h100, 8'hF0, 0, 0, 0, 0, 0, 0);
        set_vec(1, CMD_DRAW,  8'd0,  8'd0,  4'd1,  1'b0, 12'h000, 1, 1'b1, 12'h100, 8'h00, 0, 0, 0, 0, 0, 0);
        set_vec(2, CMD_DRAW,  8'd3,  8'd2,  4'd1,  1'b0, 12'h010, 2, 1'b0, 12'h110, 8'h1F, 12'h111, 8'hE0, 0, 0, 0, 0);
        set_vec(3, CMD_DRAW,  8'd61, 8'd31, 4'd2,  1'b1, 12'h010, 1, 1'b0, 12'h1FF, 8'h07, 0, 0, 0, 0, 0, 0);
        set_vec(4, CMD_DRAW,  8'd61, 8'd31, 4'd2,  1'b0, 12'h010, 4, 1'b1, 12'h1FF, 8'h00, 12'h1F8, 8'hF8,
                12'h107, 8'h07, 12'h100, 8'hF8);
        set_vec(5, 4'hF,      8'd0,  8'd0,  4'd1,  1'b0, 12'h000, 0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(6, CMD_DRAW,  8'd0,  8'd0,  4'd0,  1'b0, 12'h000, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(7, CMD_DRAW,  8'd72, 8'd37, 4'd1,  1'b0, 12'h000, 1, 1'b0, 12'h129, 8'hF0, 0, 0, 0, 0, 0, 0);
        set_vec(8, CMD_DRAW,  8'd7,  8'd10, 4'd1,  1'b0, 12'h000, 2, 1'b0, 12'h150, 8'h01, 12'h151, 8'hE0, 0, 0, 0, 0);
        set_vec(9, CMD_DRAW,  8'd60, 8'd0,  4'd1,  1'b1, 12'h010, 1, 1'b1, 12'h107, 8'h08, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(gpu_ready), 32'd1);
        chk("rst_done", 32'(gpu_done), 32'd0);
        chk("rst_collision", 32'(gpu_collision), 32'd0);
        chk("rst_read", 32'(gpu_mem_read), 32'd0);
        chk("rst_write", 32'(gpu_mem_write), 32'd0);
        chk("rst_raddr", 32'(gpu_mem_read_addr), 32'd0);
        chk("rst_waddr", 32'(gpu_mem_write_addr), 32'd0);
        chk("rst_wdata", 32'(gpu_mem_write_data), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        do_clear("clear0", 1'b0, 1'b1);

        for (int i = 0; i < NV; i++) begin
            start_cmd(vecs[i].cmd, vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].clip, vecs[i].off);
            wait_done($sformatf("v%0d", i));
            nw = wlog.size() - base_log;
            chk($sformatf("v%0d_nwrites", i), 32'(nw), 32'(vecs[i].nwr));
            for (int k = 0; k < vecs[i].nwr && k < nw; k++) begin
                chk($sformatf("v%0d_waddr%0d", i, k), 32'(wlog[base_log + k].a), 32'(vecs[i].wa[k]));
                chk($sformatf("v%0d_wdata%0d", i, k), 32'(wlog[base_log + k].d), 32'(vecs[i].wd[k]));
            end
            chk($sformatf("v%0d_collision", i), 32'(gpu_collision), 32'(vecs[i].coll));
            $display("vec %0d: cmd=%0h x=%0d y=%0d len=%0d clip=%0d writes=%0d collision=%0d",
                     i, vecs[i].cmd, vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].clip, nw, gpu_collision);
        end

        do_clear("clear1", 1'b1, 1'b0);

        // Abort a two-byte DRAW right after the left framebuffer byte has been acknowledged.
        start_cmd(CMD_DRAW, 8'd3, 8'd2, 4'd1, 1'b0, 12'h010);
        t = 0;
        while (!((n_reads - base_reads) >= 2 && gpu_mem_read_ack) && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("abort_reached_rdl", 32'(t < 200), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(gpu_ready), 32'd1);
        chk("abort_read", 32'(gpu_mem_read), 32'd0);
        chk("abort_write", 32'(gpu_mem_write), 32'd0);
        chk("abort_done", 32'(gpu_done), 32'd0);
        chk("abort_collision", 32'(gpu_collision), 32'd0);
        chk("abort_raddr", 32'(gpu_mem_read_addr), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_writes", 32'(wlog.size() - base_log), 32'd0);
        chk("abort_no_done", 32'(n_dones - base_dones), 32'd0);
        chk("abort_ready_after", 32'(gpu_ready), 32'd1);
        $display("abort: writes=%0d done=%0d ready=%0d", wlog.size() - base_log, n_dones - base_dones, gpu_ready);

        do_clear("clear2", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
